// File: rtl/memory_mapper_if.sv
// CPU data-port bus and memory-mapped target signals for memory_mapper.
// master is the CPU/target side; slave is the mapper itself.
interface memory_mapper_if #(
    parameter int wordsize = 32
);
    logic                cpu_wr;
    logic [wordsize-1:0] cpu_addr;
    logic [wordsize-1:0] cpu_writedata;
    logic [wordsize-1:0] cpu_readdata;
    logic                dmem_wr;
    logic [wordsize-1:0] dmem_readdata;
    logic                smem_wr;
    logic [wordsize-1:0] smem_readdata;
    logic [wordsize-1:0] keyb_char;
    logic [wordsize-1:0] accel_val;
    logic                sound_wr;
    logic                lights_wr;
    logic [wordsize-1:0] sound_period;
    logic [wordsize-1:0] lights_val;

    modport master (
        output cpu_wr, cpu_addr, cpu_writedata,
        output dmem_readdata, smem_readdata, keyb_char, accel_val,
        input  cpu_readdata, dmem_wr, smem_wr, sound_wr, lights_wr,
        input  sound_period, lights_val
    );

    modport slave (
        input  cpu_wr, cpu_addr, cpu_writedata,
        input  dmem_readdata, smem_readdata, keyb_char, accel_val,
        output cpu_readdata, dmem_wr, smem_wr, sound_wr, lights_wr,
        output sound_period, lights_val
    );
endinterface

// File: rtl/memory_mapper.sv
// Address decoder / read mux between the CPU data port and dmem, smem and
// the I/O block; also holds the sound-period and LED registers.
module memory_mapper #(
    parameter int wordsize = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    memory_mapper_if.slave   bus
);
    logic [15:0] region;
    logic [15:0] offset;
    logic        dmem_sel;
    logic        smem_sel;
    logic        io_sel;
    logic        keyb_sel;
    logic        accel_sel;
    logic        sound_sel;
    logic        lights_sel;
    logic        unused_addr_bits;

    assign region = bus.cpu_addr[31:16];
    assign offset = bus.cpu_addr[15:0];

    // Byte lane bits are irrelevant: only word accesses exist.
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    assign dmem_sel   = (region == 16'h1001) && (offset < 16'h1000);
    assign smem_sel   = (region == 16'h1002) && (offset < 16'h12C0);
    assign io_sel     = (region == 16'h1003) && (bus.cpu_addr[15:4] == 12'h000);
    assign keyb_sel   = io_sel && (bus.cpu_addr[3:2] == 2'b00);
    assign accel_sel  = io_sel && (bus.cpu_addr[3:2] == 2'b01);
    assign sound_sel  = io_sel && (bus.cpu_addr[3:2] == 2'b10);
    assign lights_sel = io_sel && (bus.cpu_addr[3:2] == 2'b11);

    assign bus.dmem_wr   = bus.cpu_wr && dmem_sel;
    assign bus.smem_wr   = bus.cpu_wr && smem_sel;
    assign bus.sound_wr  = bus.cpu_wr && sound_sel;
    assign bus.lights_wr = bus.cpu_wr && lights_sel;

    always_comb begin
        bus.cpu_readdata = '0;
        if (dmem_sel)
            bus.cpu_readdata = bus.dmem_readdata;
        else if (smem_sel)
            bus.cpu_readdata = bus.smem_readdata;
        else if (keyb_sel)
            bus.cpu_readdata = bus.keyb_char;
        else if (accel_sel)
            bus.cpu_readdata = bus.accel_val;
    end

    // Index 0 is the sound period, index 1 the LED value.
    logic [1:0]          io_wr;
    logic [wordsize-1:0] io_val [2];

    assign io_wr = {bus.lights_wr, bus.sound_wr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_io_reg
            logic [wordsize-1:0] value_reg;
            logic [wordsize-1:0] value_next;

            assign value_next = io_wr[gi] ? bus.cpu_writedata : value_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    value_reg <= '0;
                else
                    value_reg <= value_next;
            end

            assign io_val[gi] = value_reg;
        end
    endgenerate

    assign bus.sound_period = io_val[0];
    assign bus.lights_val   = io_val[1];
endmodule

// File: tb/tb_memory_mapper.sv
// Randomized bench for memory_mapper against an address-range reference model,
// with directed literal checks from the test plan.
module tb_memory_mapper;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    memory_mapper_if #(.wordsize(W)) bus ();

    memory_mapper #(.wordsize(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_sound = '0;
    logic [31:0] m_lights = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decide the target from plain address ranges on the word address.
    // st = {dmem, smem, sound, lights}
    function automatic void model(input logic wr, input logic [31:0] a,
                                  output logic [31:0] rd, output logic [3:0] st);
        logic [31:0] w;
        w  = {a[31:2], 2'b00};
        rd = '0;
        st = '0;
        if (w >= 32'h1001_0000 && w < 32'h1001_1000) begin
            rd = bus.dmem_readdata; st[3] = wr;
        end else if (w >= 32'h1002_0000 && w < 32'h1002_12C0) begin
            rd = bus.smem_readdata; st[2] = wr;
        end else if (w >= 32'h1003_0000 && w < 32'h1003_0010) begin
            case ((w - 32'h1003_0000) / 4)
                0: rd = bus.keyb_char;
                1: rd = bus.accel_val;
                2: st[1] = wr;
                default: st[0] = wr;
            endcase
        end
    endfunction

    always @(posedge clk) begin : model_regs
        logic [31:0] rd;
        logic [3:0]  st;
        if (reset_n) begin
            model(bus.cpu_wr, bus.cpu_addr, rd, st);
            if (st[1]) m_sound  = bus.cpu_writedata;
            if (st[0]) m_lights = bus.cpu_writedata;
        end
    end

    always @(negedge reset_n) begin
        m_sound  = '0;
        m_lights = '0;
    end

    always @(negedge clk) begin : compare
        logic [31:0] rd;
        logic [3:0]  st;
        model(bus.cpu_wr, bus.cpu_addr, rd, st);
        check("readdata", bus.cpu_readdata, rd);
        check("strobes", {28'h0, bus.dmem_wr, bus.smem_wr, bus.sound_wr, bus.lights_wr}, {28'h0, st});
        check("sound_period", bus.sound_period, m_sound);
        check("lights_val", bus.lights_val, m_lights);
    end

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk);
        #2;
        bus.cpu_wr        = wr;
        bus.cpu_addr      = addr;
        bus.cpu_writedata = wd;
        #1;
    endtask

    function automatic logic [31:0] strobes();
        return {28'h0, bus.dmem_wr, bus.smem_wr, bus.sound_wr, bus.lights_wr};
    endfunction

    initial begin
        logic [31:0] bounds [8];
        bounds = '{32'h1001_0FFC, 32'h1001_1000, 32'h1002_12BC, 32'h1002_12C0,
                   32'h1003_000C, 32'h1003_0010, 32'h1000_FFFC, 32'h1004_0000};

        bus.cpu_wr        = 1'b0;
        bus.cpu_addr      = '0;
        bus.cpu_writedata = '0;
        bus.dmem_readdata = '0;
        bus.smem_readdata = '0;
        bus.keyb_char     = '0;
        bus.accel_val     = '0;
        #1;
        check("reset_sound", bus.sound_period, 32'h0);
        check("reset_lights", bus.lights_val, 32'h0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Directed test-plan items with literal expectations
        bus.dmem_readdata = 32'h1234_5678;
        drive(1'b0, 32'h1001_0000, 32'h0);
        check("dmem_rd_lo", bus.cpu_readdata, 32'h1234_5678);
        check("dmem_rd_lo_strb", strobes(), 32'h0);
        bus.dmem_readdata = 32'h5678_1234;
        drive(1'b0, 32'h1001_0FFC, 32'h0);
        check("dmem_rd_hi", bus.cpu_readdata, 32'h5678_1234);
        drive(1'b1, 32'h1001_0000, 32'hDEAD_0001);
        check("dmem_wr_lo", strobes(), 32'h8);
        drive(1'b1, 32'h1001_0FFC, 32'hDEAD_0002);
        check("dmem_wr_hi", strobes(), 32'h8);
        drive(1'b1, 32'h1002_0000, 32'hDEAD_0003);
        check("smem_wr_lo", strobes(), 32'h4);
        drive(1'b1, 32'h1002_12BC, 32'hDEAD_0004);
        check("smem_wr_hi", strobes(), 32'h4);
        drive(1'b1, 32'h1002_12C0, 32'hDEAD_0005);
        check("smem_wr_oob", strobes(), 32'h0);
        bus.keyb_char = 32'h2468_1234;
        drive(1'b0, 32'h1003_0000, 32'h0);
        check("keyb_rd", bus.cpu_readdata, 32'h2468_1234);
        bus.accel_val = 32'h1357_2468;
        drive(1'b0, 32'h1003_0004, 32'h0);
        check("accel_rd", bus.cpu_readdata, 32'h1357_2468);
        bus.accel_val = 32'h0BAD_F00D;
        #1;
        check("accel_passthru", bus.cpu_readdata, 32'h0BAD_F00D);
        drive(1'b1, 32'h1003_0004, 32'hFFFF_FFFF);
        check("accel_wr_none", strobes(), 32'h0);
        drive(1'b1, 32'h1003_0008, 32'h0000_03E8);
        check("sound_wr", strobes(), 32'h2);
        @(posedge clk);
        #1;
        check("sound_val", bus.sound_period, 32'h0000_03E8);
        drive(1'b1, 32'h1003_000C, 32'h0000_A5A5);
        check("lights_wr", strobes(), 32'h1);
        @(posedge clk);
        #1;
        check("lights_val_lit", bus.lights_val, 32'h0000_A5A5);
        check("sound_hold", bus.sound_period, 32'h0000_03E8);
        drive(1'b0, 32'h1003_000C, 32'h0000_A5A5);
        check("wr_cleared", strobes(), 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_sound", bus.sound_period, 32'h0);
        check("rst_lights", bus.lights_val, 32'h0);
        #1 reset_n = 1'b1;
        drive(1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        check("unmapped_rd", bus.cpu_readdata, 32'h0);
        check("unmapped_strb", strobes(), 32'h0);
        // A sound write held across a clock edge while in reset is discarded
        drive(1'b1, 32'h1003_0008, 32'h0000_1234);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("wr_in_reset", bus.sound_period, 32'h0);
        reset_n = 1'b1;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0: a = 32'h1001_0000 + $urandom_range(0, 32'h1100);
                1: a = 32'h1002_0000 + $urandom_range(0, 32'h1400);
                2: a = 32'h1003_0000 + $urandom_range(0, 32'h1F);
                3: a = $urandom;
                4: a = bounds[$urandom_range(0, 7)];
                default: a = {16'h1000 + 16'($urandom_range(0, 4)), 16'($urandom)};
            endcase
            bus.dmem_readdata = $urandom;
            bus.smem_readdata = $urandom;
            bus.keyb_char     = $urandom;
            bus.accel_val     = $urandom;
            drive(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 63) == 0) begin
                reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
